frame_parity_checker: RTL and testbench
=======================================

FRAME_PARITY_CHECKER -- requirements
Module: frame_parity_checker

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 3, meaning the number of serial bits per frame (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the statistics counters (legal range 2..32).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; it is sampled only on the rising edge of clk.
REQ-005 The block SHALL have port in_valid, input, 1 bit: inp is accepted on this cycle.
REQ-006 The block SHALL have port inp, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port odd_mode, input, 1 bit: 1 = frame is good when its ones-count is odd; 0 = good when even.
REQ-008 The block SHALL have port frame_abort, input, 1 bit: discard the partial frame.
REQ-009 The block SHALL have port clear_stats, input, 1 bit: zero both counters.
REQ-010 The block SHALL have port out, output, 1 bit: registered result for the last completed frame (1 = parity good).
REQ-011 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result on out.
REQ-012 The block SHALL have port err_count, output, CNT_W bits: number of bad frames, saturating.
REQ-013 The block SHALL have port frame_count, output, CNT_W bits: number of completed frames, wrapping.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (no bits of the current frame accepted) and COLLECT (1..FRAME_LEN-1 bits accepted).
REQ-015 In IDLE, in_valid=1 SHALL load running parity with inp, latch odd_mode into mode_q, set bit index to 1, and move to COLLECT.
REQ-016 In COLLECT, in_valid=1 SHALL XOR inp into running parity and increment bit index.
REQ-017 Accepting the FRAME_LEN-th bit SHALL return the FSM to IDLE, with the bit index cleared to 0.
REQ-018 in_valid=0 SHALL hold state, bit index and parity unchanged (gaps allowed mid-frame).
REQ-019 Changes to odd_mode after the first bit of a frame SHALL be ignored until the next frame; mode_q governs that frame.
REQ-020 On the cycle after the last bit is accepted, out SHALL equal (final parity == mode_q), out_valid SHALL be 1, frame_count SHALL have incremented by 1 (wrapping), and err_count SHALL have incremented by 1 if out=0.
REQ-021 Result latency SHALL be exactly 1 clock from acceptance of the last bit.
REQ-022 out SHALL hold its value between out_valid pulses; out_valid SHALL be high only for the result cycle.
REQ-023 err_count SHALL saturate at 2^CNT_W-1, and frame_count SHALL wrap to 0.
REQ-024 frame_abort=1 SHALL force IDLE, clear the bit index and running parity, and produce no out_valid.
REQ-025 frame_abort SHALL take priority over a simultaneous in_valid bit, including a would-be last bit; that bit is discarded.
REQ-026 When frame_abort is asserted in IDLE, the bit presented with it SHALL NOT start a frame.
REQ-027 clear_stats=1 SHALL zero err_count and frame_count on the next edge.
REQ-028 When clear_stats and frame completion occur in the same cycle, clear SHALL win: both counters are 0 afterwards, while out and out_valid are still produced.
REQ-029 For FRAME_LEN=2, IDLE->COLLECT->IDLE SHALL be the complete frame cycle; no state is skipped.

Reset
REQ-030 reset=0 at a rising edge SHALL set: FSM=IDLE, bit index=0, parity=0, mode_q=0, out=0, out_valid=0, err_count=0, frame_count=0.
REQ-031 Reset SHALL take priority over all other inputs; a partial frame in progress SHALL be discarded without producing out_valid.
REQ-032 Outputs SHALL NOT change asynchronously with reset.

Verification
REQ-033 With FRAME_LEN=3 and odd_mode=1, bits 1,0,0 on consecutive cycles -> one cycle later out=1, out_valid=1, frame_count=1, err_count=0.
REQ-034 With FRAME_LEN=3 and odd_mode=0, bits 1,1,1 with two idle cycles between bits 2 and 3 -> out=0, out_valid pulses once, err_count=1.
REQ-035 Mode latch: odd_mode=1 at bit 1, then odd_mode=0 for bits 2-3, with bits 0,1,0 -> out=1 (odd rule applied).
REQ-036 Abort: bits 1,1, then frame_abort with a valid bit, then bits 0,0,1 -> exactly one out_valid, out=1 for odd_mode=1, frame_count=1.
REQ-037 Saturation/wrap: CNT_W=2, five bad frames -> err_count=3 and frame_count=1; clear_stats coincident with the sixth frame end -> both counters 0, out_valid=1.
REQ-038 Reset mid-frame: reset=0 after 2 of 3 bits -> no out_valid; all outputs 0; the next 3 bits form a fresh frame.

Source files
------------

// File: rtl/frame_parity_checker.sv
// Serial frame parity checker: accumulates FRAME_LEN bits per frame, reports
// good/bad parity one cycle after the last bit and keeps bad/total frame counts.
module frame_parity_checker #(
    parameter int unsigned FRAME_LEN = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             inp,
    input  logic             odd_mode,
    input  logic             frame_abort,
    input  logic             clear_stats,
    output logic             out,
    output logic             out_valid,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             par_q, par_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             frame_done;
    logic             final_par;

    // Next-state, result and statistics logic; abort beats any accepted bit.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        par_d       = par_q;
        mode_d      = mode_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        frame_d     = frame_q;
        frame_done  = 1'b0;
        final_par   = par_q ^ inp;

        if (frame_abort) begin
            state_d = IDLE;
            idx_d   = '0;
            par_d   = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    par_d   = inp;
                    mode_d  = odd_mode;
                    idx_d   = IDX_W'(1);
                    state_d = COLLECT;
                end
                COLLECT: begin
                    if (idx_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        idx_d      = '0;
                        par_d      = 1'b0;
                    end else begin
                        par_d = final_par;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (frame_done) begin
            out_valid_d = 1'b1;
            out_d       = (final_par == mode_q);
            frame_d     = frame_q + CNT_W'(1);
            if ((final_par != mode_q) && (err_q != CNT_MAX)) begin
                err_d = err_q + CNT_W'(1);
            end
        end

        // Clearing the statistics overrides a coincident frame completion.
        if (clear_stats) begin
            err_d   = '0;
            frame_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            par_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign err_count   = err_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_frame_parity_checker.sv
// Directed bench for frame_parity_checker: an 8-bit-counter instance and a
// 2-bit-counter instance share one stimulus stream.
module tb_frame_parity_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       inp;
    logic       odd_mode;
    logic       frame_abort;
    logic       clear_stats;

    logic       out8, out_valid8;
    logic [7:0] err8, frm8;
    logic       out2, out_valid2;
    logic [1:0] err2, frm2;

    int vectors;
    int miscompares;

    frame_parity_checker #(.FRAME_LEN(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .inp(inp),
        .odd_mode(odd_mode), .frame_abort(frame_abort), .clear_stats(clear_stats),
        .out(out8), .out_valid(out_valid8), .err_count(err8), .frame_count(frm8)
    );

    frame_parity_checker #(.FRAME_LEN(3), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .inp(inp),
        .odd_mode(odd_mode), .frame_abort(frame_abort), .clear_stats(clear_stats),
        .out(out2), .out_valid(out_valid2), .err_count(err2), .frame_count(frm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        inp      = b;
        cyc();
        in_valid = 1'b0;
        inp      = 1'b0;
    endtask

    task automatic send_frame(input logic b0, input logic b1, input logic b2);
        send_bit(b0);
        send_bit(b1);
        send_bit(b2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_valid    = 1'b1;
        inp         = 1'b1;
        odd_mode    = 1'b1;
        frame_abort = 1'b0;
        clear_stats = 1'b0;

        // Reset with live input traffic
        cyc();
        cyc();
        chk("rst_out", 32'(out8), 0);
        chk("rst_ov", 32'(out_valid8), 0);
        chk("rst_err", 32'(err8), 0);
        chk("rst_frm", 32'(frm8), 0);
        chk("rst_err2", 32'(err2), 0);
        in_valid = 1'b0;
        inp      = 1'b0;
        reset    = 1'b1;
        cyc();

        // Odd mode, bits 1,0,0 back to back
        odd_mode = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        chk("b33_ov_early", 32'(out_valid8), 0);
        send_bit(1'b0);
        chk("b33_out", 32'(out8), 1);
        chk("b33_ov", 32'(out_valid8), 1);
        chk("b33_frm", 32'(frm8), 1);
        chk("b33_err", 32'(err8), 0);
        cyc();
        chk("b33_ov_pulse", 32'(out_valid8), 0);
        chk("b33_out_hold", 32'(out8), 1);

        // Even mode, bits 1,1,(gap,gap),1
        odd_mode = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        cyc();
        chk("b34_gap_ov", 32'(out_valid8), 0);
        cyc();
        send_bit(1'b1);
        chk("b34_out", 32'(out8), 0);
        chk("b34_ov", 32'(out_valid8), 1);
        chk("b34_err", 32'(err8), 1);
        chk("b34_frm", 32'(frm8), 2);
        cyc();
        chk("b34_ov_pulse", 32'(out_valid8), 0);
        chk("b34_out_hold", 32'(out8), 0);

        // Mode latched at first bit: odd rule governs bits 0,1,0
        odd_mode = 1'b1;
        send_bit(1'b0);
        odd_mode = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        chk("b35_out", 32'(out8), 1);
        chk("b35_ov", 32'(out_valid8), 1);
        chk("b35_frm", 32'(frm8), 3);
        chk("b35_err", 32'(err8), 1);

        // Statistics clear
        clear_stats = 1'b1;
        cyc();
        clear_stats = 1'b0;
        chk("clr_err", 32'(err8), 0);
        chk("clr_frm", 32'(frm8), 0);

        // Abort on the would-be last bit, then a fresh frame 0,0,1
        odd_mode = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        frame_abort = 1'b1;
        send_bit(1'b1);
        frame_abort = 1'b0;
        chk("b36_abort_ov", 32'(out_valid8), 0);
        chk("b36_abort_frm", 32'(frm8), 0);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("b36_ov_early", 32'(out_valid8), 0);
        send_bit(1'b1);
        chk("b36_out", 32'(out8), 1);
        chk("b36_ov", 32'(out_valid8), 1);
        chk("b36_frm", 32'(frm8), 1);

        // Abort in IDLE: its bit must not start a frame
        odd_mode    = 1'b0;
        frame_abort = 1'b1;
        send_bit(1'b1);
        frame_abort = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("idle_abort_ov", 32'(out_valid8), 0);
        send_bit(1'b0);
        chk("idle_abort_out", 32'(out8), 1);
        chk("idle_abort_frm", 32'(frm8), 2);

        // Reset mid-frame discards the partial frame
        odd_mode = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("b38_out", 32'(out8), 0);
        chk("b38_ov", 32'(out_valid8), 0);
        chk("b38_frm", 32'(frm8), 0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("b38_ov_early", 32'(out_valid8), 0);
        send_bit(1'b0);
        chk("b38_new_out", 32'(out8), 1);
        chk("b38_new_ov", 32'(out_valid8), 1);
        chk("b38_new_frm", 32'(frm8), 1);

        // Saturation / wrap on the 2-bit counters: bad frames under even rule
        reset = 1'b0;
        cyc();
        reset    = 1'b1;
        odd_mode = 1'b0;
        repeat (3) send_frame(1'b1, 1'b0, 1'b0);
        chk("b37_out_bad", 32'(out2), 0);
        chk("b37_err_3", 32'(err2), 3);
        chk("b37_frm_3", 32'(frm2), 3);
        send_frame(1'b1, 1'b0, 1'b0);
        chk("b37_err_sat", 32'(err2), 3);
        chk("b37_frm_wrap", 32'(frm2), 0);
        send_frame(1'b1, 1'b0, 1'b0);
        chk("b37_err_5", 32'(err2), 3);
        chk("b37_frm_5", 32'(frm2), 1);
        chk("b37_err8_5", 32'(err8), 5);
        send_bit(1'b1);
        send_bit(1'b0);
        clear_stats = 1'b1;
        send_bit(1'b0);
        clear_stats = 1'b0;
        chk("b37_clr_err", 32'(err2), 0);
        chk("b37_clr_frm", 32'(frm2), 0);
        chk("b37_clr_ov", 32'(out_valid2), 1);
        chk("b37_clr_out", 32'(out2), 0);
        chk("b37_clr_err8", 32'(err8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
